// File: rtl/pipe_reg.sv
// Flow-controlled register pipeline: DEPTH stages of WIDTH bits with valid/ready and bubble collapsing.
// Define PIPE_OCCUPANCY_EN to add the occupancy port and its counter.
module pipe_reg_stage #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);
  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // Data only moves with a valid word so a drained stage keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 1'b0;
      r_d <= RST_VAL;
    end else if (clr) begin
      r_v <= 1'b0;
    end else if (i_en) begin
      r_v <= i_vld;
      if (i_vld) r_d <= i_data;
    end
  end

  assign o_vld  = r_v;
  assign o_data = r_d;
endmodule

module pipe_reg #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
  logic [DEPTH:0]                w_rdy;
  logic [DEPTH-1:0]              w_v;
  logic [DEPTH-1:0]              w_uv;
  logic [DEPTH-1:0][WIDTH-1:0]   w_d;
  logic [DEPTH-1:0][WIDTH-1:0]   w_ud;

  assign w_rdy[DEPTH] = out_ready;
  assign w_uv[0]      = in_valid & ~clr;
  assign w_ud[0]      = in_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i > 0) begin : g_link
      assign w_uv[i] = w_v[i-1];
      assign w_ud[i] = w_d[i-1];
    end
    // An empty stage always accepts, which collapses bubbles under backpressure.
    assign w_rdy[i] = ~w_v[i] | w_rdy[i+1];

    pipe_reg_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stg (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .i_en   (w_rdy[i]),
      .i_vld  (w_uv[i]),
      .i_data (w_ud[i]),
      .o_vld  (w_v[i]),
      .o_data (w_d[i])
    );
  end

  assign in_ready  = w_rdy[0] & ~clr;
  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int OW = $clog2(DEPTH+1);
  logic [OW-1:0] r_occ;
  logic          w_in_xfer;
  logic          w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_occ <= '0;
    else if (clr)                      r_occ <= '0;
    else if (w_in_xfer & ~w_out_xfer)  r_occ <= r_occ + OW'(1);
    else if (w_out_xfer & ~w_in_xfer)  r_occ <= r_occ - OW'(1);
  end

  assign occupancy = r_occ;
`endif
endmodule

// File: tb/tb_pipe_reg.sv
// Directed and scoreboarded checks for pipe_reg at DEPTH=4/WIDTH=8 and DEPTH=1/WIDTH=16.
module tb_pipe_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_id, a_od;
  logic        b_iv, b_ir, b_ov, b_or;
  logic        b_clr = 1'b0;
  logic [15:0] b_id, b_od;
`ifdef PIPE_OCCUPANCY_EN
  logic [2:0] a_occ;
  logic [0:0] b_occ;
`endif

  pipe_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(a_occ)
`endif
  );

  pipe_reg #(.WIDTH(16), .DEPTH(1), .RST_VAL(16'h0000)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(b_occ)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycle;
    #1;
`ifdef PIPE_OCCUPANCY_EN
    chk("rnd_occ", 32'(a_occ), 32'(q.size()));
`endif
    if (a_ov && a_or) begin
      chk("rnd_qsz", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("rnd_data", 32'(a_od), 32'(q.pop_front()));
    end
    if (a_iv && a_ir) q.push_back(a_id);
    tick();
  endtask

  initial begin
    a_iv = 0; a_id = '0; a_or = 1;
    b_iv = 0; b_id = '0; b_or = 1;
    repeat (2) tick();
    #1;
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_od", 32'(a_od), 0);
    chk("rst_ir", 32'(a_ir), 1);
    chk("rst_b_ov", 32'(b_ov), 0);
    chk("rst_b_od", 32'(b_od), 0);
`ifdef PIPE_OCCUPANCY_EN
    chk("rst_occ", 32'(a_occ), 0);
`endif
    rst = 1'b0;
    tick();

    // stream 0x01..0x10 with out_ready held high
    for (int j = 0; j <= 20; j++) begin
      a_iv = (j < 16);
      a_id = 8'(j + 1);
      #1;
      chk("str_ir", 32'(a_ir), 1);
      chk("str_ov", 32'(a_ov), 32'((j >= 4) && (j <= 19)));
      if (j >= 4 && j <= 19) chk("str_od", 32'(a_od), 32'(j - 3));
      tick();
    end

    // fill, then reset in the middle of a cycle
    a_or = 0; a_iv = 1; a_id = 8'h77;
    repeat (4) tick();
    a_iv = 0;
    #1;
    chk("mr_full_ov", 32'(a_ov), 1);
    chk("mr_full_ir", 32'(a_ir), 0);
    #2 rst = 1'b1;
    #1;
    chk("mr_ov", 32'(a_ov), 0);
    chk("mr_od", 32'(a_od), 0);
    chk("mr_ir", 32'(a_ir), 1);
`ifdef PIPE_OCCUPANCY_EN
    chk("mr_occ", 32'(a_occ), 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // backpressure fill then simultaneous in/out
    a_or = 0;
    for (int k = 0; k < 4; k++) begin
      a_iv = 1; a_id = 8'(8'hA0 + k);
      #1;
      chk("bp_ir", 32'(a_ir), 1);
      tick();
    end
    a_iv = 0;
    #1;
    chk("bp_full_ir", 32'(a_ir), 0);
    chk("bp_full_ov", 32'(a_ov), 1);
    chk("bp_full_od", 32'(a_od), 32'hA0);
`ifdef PIPE_OCCUPANCY_EN
    chk("bp_full_occ", 32'(a_occ), 4);
`endif
    a_or = 1; a_iv = 1; a_id = 8'hA4;
    #1;
    chk("bp_rel_ir", 32'(a_ir), 1);
    tick();
    a_iv = 0;
`ifdef PIPE_OCCUPANCY_EN
    chk("bp_rel_occ", 32'(a_occ), 4);
`endif
    for (int k = 1; k <= 4; k++) begin
      chk("bp_drain_ov", 32'(a_ov), 1);
      chk("bp_drain_od", 32'(a_od), 32'(8'hA0 + k));
      tick();
    end
    chk("bp_empty_ov", 32'(a_ov), 0);

    // bubble collapse
    a_or = 0; a_iv = 1; a_id = 8'h11;
    tick();
    a_iv = 0;
    repeat (2) tick();
    a_iv = 1; a_id = 8'h22;
    #1;
    chk("bub_ir", 32'(a_ir), 1);
    tick();
    a_iv = 0;
    repeat (4) tick();
    chk("bub_ov", 32'(a_ov), 1);
    chk("bub_od0", 32'(a_od), 32'h11);
    chk("bub_ir2", 32'(a_ir), 1);
`ifdef PIPE_OCCUPANCY_EN
    chk("bub_occ", 32'(a_occ), 2);
`endif
    a_or = 1;
    tick();
    chk("bub_od1_ov", 32'(a_ov), 1);
    chk("bub_od1", 32'(a_od), 32'h22);
    tick();
    chk("bub_end_ov", 32'(a_ov), 0);

    // flush with three words in flight
    a_or = 0;
    for (int k = 0; k < 3; k++) begin
      a_iv = 1; a_id = 8'(8'h31 + k);
      tick();
    end
    clr = 1; a_iv = 1; a_id = 8'h55;
    #1;
    chk("fl_ir", 32'(a_ir), 0);
    tick();
    clr = 0; a_iv = 0; a_or = 1;
    #1;
    chk("fl_ov", 32'(a_ov), 0);
`ifdef PIPE_OCCUPANCY_EN
    chk("fl_occ", 32'(a_occ), 0);
`endif
    for (int k = 0; k < 6; k++) begin
      chk("fl_never", 32'(a_ov), 0);
      tick();
    end

    // DEPTH=1 with alternating out_ready
    b_or = 1; b_iv = 1; b_id = 16'h1234;
    #1;
    chk("d1_ir0", 32'(b_ir), 1);
    tick();
    b_or = 0; b_id = 16'h5678;
    #1;
    chk("d1_ir1", 32'(b_ir), 0);
    chk("d1_ov1", 32'(b_ov), 1);
    chk("d1_od1", 32'(b_od), 32'h1234);
    tick();
    chk("d1_hold", 32'(b_od), 32'h1234);
    b_or = 1;
    #1;
    chk("d1_ir2", 32'(b_ir), 1);
    tick();
    chk("d1_od2", 32'(b_od), 32'h5678);
    b_iv = 0; b_or = 0;
    tick();
    chk("d1_hold2", 32'(b_od), 32'h5678);
    chk("d1_hold2_ov", 32'(b_ov), 1);
    b_or = 1;
    tick();
    chk("d1_empty", 32'(b_ov), 0);

    // random valid/ready against a scoreboard
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      a_iv = 1'($urandom_range(0, 1));
      a_id = 8'($urandom);
      a_or = ($urandom_range(0, 2) != 0);
      rnd_cycle();
    end
    a_iv = 0; a_or = 1;
    for (int n = 0; n < 8; n++) rnd_cycle();
    chk("rnd_drain", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
